// File: rtl/pool_window_tracker_if.sv
// Pixel-side bundle of the pool window tracker: strobe/clear in, per-pixel position and window flags out.
interface pool_window_tracker_if #(
    parameter int CW  = 8,
    parameter int RW  = 8,
    parameter int OCW = 7,
    parameter int ORW = 7
);
    logic           Data_In;
    logic           frame_clr;
    logic           Data_Out;
    logic [CW-1:0]  col;
    logic [RW-1:0]  row;
    logic           pool_valid;
    logic [OCW-1:0] pool_col;
    logic [ORW-1:0] pool_row;
    logic           line_end;
    logic           frame_end;
    logic           busy;
    logic           overflow;

    modport master (
        output Data_In, frame_clr,
        input  Data_Out, col, row, pool_valid, pool_col, pool_row,
               line_end, frame_end, busy, overflow
    );

    modport slave (
        input  Data_In, frame_clr,
        output Data_Out, col, row, pool_valid, pool_col, pool_row,
               line_end, frame_end, busy, overflow
    );
endinterface

// File: rtl/pool_window_tracker.sv
// Raster-scan position tracker that flags the pixel closing each POOL x POOL window at
// stride STRIDE, plus line/frame end, for the max-pool compare and line-buffer logic.
module pool_window_tracker #(
    parameter int IMG_WIDTH  = 220,
    parameter int IMG_HEIGHT = 220,
    parameter int POOL       = 2,
    parameter int STRIDE     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    pool_window_tracker_if.slave bus
);
    localparam int OUT_W = (IMG_WIDTH - POOL) / STRIDE + 1;
    localparam int OUT_H = (IMG_HEIGHT - POOL) / STRIDE + 1;
    localparam int CW    = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW    = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int OCW   = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int ORW   = (OUT_H > 1) ? $clog2(OUT_H) : 1;
    localparam int PW    = (POOL > 1) ? $clog2(POOL) : 1;

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    state_t         state_q;
    logic [CW-1:0]  colCnt_q,   colCnt_d;
    logic [RW-1:0]  rowCnt_q,   rowCnt_d;
    logic [PW-1:0]  colPhase_q, colPhase_d;
    logic [PW-1:0]  rowPhase_q, rowPhase_d;
    logic [OCW-1:0] colIdx_q,   colIdx_d;
    logic [ORW-1:0] rowIdx_q,   rowIdx_d;
    logic           colExh_q,   colExh_d;
    logic           rowExh_q,   rowExh_d;

    logic           dataOut_q, poolValid_q, lineEnd_q, frameEnd_q, overflow_q;
    logic [CW-1:0]  col_q;
    logic [RW-1:0]  row_q;
    logic [OCW-1:0] poolCol_q;
    logic [ORW-1:0] poolRow_q;

    logic accept, lastCol, lastRow, colHit, rowHit;

    // Phase counts pixels since the last window edge: POOL-1 to the first, STRIDE-1 after.
    // The Exh flags stop hits once OUT_W/OUT_H windows have closed, masking trailing pixels.
    always_comb begin
        accept     = bus.Data_In && !bus.frame_clr && (state_q != DONE);
        lastCol    = (colCnt_q == CW'(IMG_WIDTH - 1));
        lastRow    = (rowCnt_q == RW'(IMG_HEIGHT - 1));
        colHit     = !colExh_q &&
                     (colPhase_q == ((colIdx_q == '0) ? PW'(POOL - 1) : PW'(STRIDE - 1)));
        rowHit     = !rowExh_q &&
                     (rowPhase_q == ((rowIdx_q == '0) ? PW'(POOL - 1) : PW'(STRIDE - 1)));
        colCnt_d   = colCnt_q;
        rowCnt_d   = rowCnt_q;
        colPhase_d = colPhase_q;
        rowPhase_d = rowPhase_q;
        colIdx_d   = colIdx_q;
        rowIdx_d   = rowIdx_q;
        colExh_d   = colExh_q;
        rowExh_d   = rowExh_q;
        if (bus.frame_clr) begin
            colCnt_d   = '0;
            rowCnt_d   = '0;
            colPhase_d = '0;
            rowPhase_d = '0;
            colIdx_d   = '0;
            rowIdx_d   = '0;
            colExh_d   = 1'b0;
            rowExh_d   = 1'b0;
        end else if (accept) begin
            if (lastCol) begin
                colCnt_d   = '0;
                colPhase_d = '0;
                colIdx_d   = '0;
                colExh_d   = 1'b0;
                if (lastRow) begin
                    rowCnt_d   = '0;
                    rowPhase_d = '0;
                    rowIdx_d   = '0;
                    rowExh_d   = 1'b0;
                end else begin
                    rowCnt_d = rowCnt_q + RW'(1);
                    if (rowHit) begin
                        rowPhase_d = '0;
                        if (rowIdx_q == ORW'(OUT_H - 1)) rowExh_d = 1'b1;
                        else                             rowIdx_d = rowIdx_q + ORW'(1);
                    end else if (!rowExh_q) begin
                        rowPhase_d = rowPhase_q + PW'(1);
                    end
                end
            end else begin
                colCnt_d = colCnt_q + CW'(1);
                if (colHit) begin
                    colPhase_d = '0;
                    if (colIdx_q == OCW'(OUT_W - 1)) colExh_d = 1'b1;
                    else                             colIdx_d = colIdx_q + OCW'(1);
                end else if (!colExh_q) begin
                    colPhase_d = colPhase_q + PW'(1);
                end
            end
        end
    end

    // frame_clr outranks a coincident pixel; pulses default low, positions hold.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            colCnt_q    <= '0;
            rowCnt_q    <= '0;
            colPhase_q  <= '0;
            rowPhase_q  <= '0;
            colIdx_q    <= '0;
            rowIdx_q    <= '0;
            colExh_q    <= 1'b0;
            rowExh_q    <= 1'b0;
            dataOut_q   <= 1'b0;
            poolValid_q <= 1'b0;
            lineEnd_q   <= 1'b0;
            frameEnd_q  <= 1'b0;
            overflow_q  <= 1'b0;
            col_q       <= '0;
            row_q       <= '0;
            poolCol_q   <= '0;
            poolRow_q   <= '0;
        end else begin
            colCnt_q    <= colCnt_d;
            rowCnt_q    <= rowCnt_d;
            colPhase_q  <= colPhase_d;
            rowPhase_q  <= rowPhase_d;
            colIdx_q    <= colIdx_d;
            rowIdx_q    <= rowIdx_d;
            colExh_q    <= colExh_d;
            rowExh_q    <= rowExh_d;
            dataOut_q   <= 1'b0;
            poolValid_q <= 1'b0;
            lineEnd_q   <= 1'b0;
            frameEnd_q  <= 1'b0;
            if (bus.frame_clr) begin
                state_q    <= IDLE;
                overflow_q <= 1'b0;
            end else if (accept) begin
                dataOut_q   <= 1'b1;
                col_q       <= colCnt_q;
                row_q       <= rowCnt_q;
                lineEnd_q   <= lastCol;
                frameEnd_q  <= lastCol && lastRow;
                poolValid_q <= colHit && rowHit;
                if (colHit && rowHit) begin
                    poolCol_q <= colIdx_q;
                    poolRow_q <= rowIdx_q;
                end
                state_q <= (lastCol && lastRow) ? DONE : ACTIVE;
            end else if (bus.Data_In && (state_q == DONE)) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign bus.Data_Out   = dataOut_q;
    assign bus.col        = col_q;
    assign bus.row        = row_q;
    assign bus.pool_valid = poolValid_q;
    assign bus.pool_col   = poolCol_q;
    assign bus.pool_row   = poolRow_q;
    assign bus.line_end   = lineEnd_q;
    assign bus.frame_end  = frameEnd_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_pool_window_tracker.sv
// Bench for pool_window_tracker: two 5x4 instances (2/2 and 3/1) against an arithmetic
// reference model, plus a full 220x220 frame on a default-sized instance.
module tb_pool_window_tracker;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pool_window_tracker_if #(.CW(3), .RW(2), .OCW(1), .ORW(1)) busA ();
    pool_window_tracker_if #(.CW(3), .RW(2), .OCW(2), .ORW(1)) busB ();
    pool_window_tracker_if #(.CW(8), .RW(8), .OCW(7), .ORW(7)) busC ();

    pool_window_tracker #(.IMG_WIDTH(5), .IMG_HEIGHT(4), .POOL(2), .STRIDE(2))
        dutA (.clk(clk), .rst(rst), .bus(busA));
    pool_window_tracker #(.IMG_WIDTH(5), .IMG_HEIGHT(4), .POOL(3), .STRIDE(1))
        dutB (.clk(clk), .rst(rst), .bus(busB));
    pool_window_tracker #(.IMG_WIDTH(220), .IMG_HEIGHT(220), .POOL(2), .STRIDE(2))
        dutC (.clk(clk), .rst(rst), .bus(busC));

    int errors = 0;
    int checks = 0;

    int cfgW[2] = '{5, 5};
    int cfgH[2] = '{4, 4};
    int cfgP[2] = '{2, 3};
    int cfgS[2] = '{2, 1};

    int mN[2], mCol[2], mRow[2], mPc[2], mPr[2];
    bit mDone[2], mBusy[2], mOvf[2];
    bit eDout[2], ePv[2], eLe[2], eFe[2];
    int pvSeen[2];

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit winHit(input int c, input int p, input int s, input int outN);
        return (c >= p - 1) && (((c - p + 1) % s) == 0) && (((c - p + 1) / s) < outN);
    endfunction

    task automatic modelStep(input bit d, input bit c, input bit rn);
        for (int k = 0; k < 2; k++) begin
            int x, y, ow, oh;
            eDout[k] = 0; ePv[k] = 0; eLe[k] = 0; eFe[k] = 0;
            if (!rn) begin
                mN[k] = 0; mCol[k] = 0; mRow[k] = 0; mPc[k] = 0; mPr[k] = 0;
                mDone[k] = 0; mBusy[k] = 0; mOvf[k] = 0;
            end else if (c) begin
                mN[k] = 0; mDone[k] = 0; mBusy[k] = 0; mOvf[k] = 0;
            end else if (d && mDone[k]) begin
                mOvf[k] = 1;
            end else if (d) begin
                x  = mN[k] % cfgW[k];
                y  = mN[k] / cfgW[k];
                ow = (cfgW[k] - cfgP[k]) / cfgS[k] + 1;
                oh = (cfgH[k] - cfgP[k]) / cfgS[k] + 1;
                eDout[k] = 1;
                mCol[k]  = x;
                mRow[k]  = y;
                eLe[k]   = (x == cfgW[k] - 1);
                eFe[k]   = eLe[k] && (y == cfgH[k] - 1);
                if (winHit(x, cfgP[k], cfgS[k], ow) && winHit(y, cfgP[k], cfgS[k], oh)) begin
                    ePv[k] = 1;
                    mPc[k] = (x - cfgP[k] + 1) / cfgS[k];
                    mPr[k] = (y - cfgP[k] + 1) / cfgS[k];
                end
                mBusy[k] = 1;
                mN[k]++;
                if (eFe[k]) begin
                    mDone[k] = 1;
                    mN[k]    = 0;
                end
            end
        end
    endtask

    task automatic checkOutput();
        for (int k = 0; k < 2; k++) begin
            logic [31:0] o[10];
            string n;
            if (k == 0) begin
                n = "A";
                o[0] = 32'(busA.Data_Out);   o[1] = 32'(busA.col);      o[2] = 32'(busA.row);
                o[3] = 32'(busA.pool_valid); o[4] = 32'(busA.pool_col); o[5] = 32'(busA.pool_row);
                o[6] = 32'(busA.line_end);   o[7] = 32'(busA.frame_end);
                o[8] = 32'(busA.busy);       o[9] = 32'(busA.overflow);
            end else begin
                n = "B";
                o[0] = 32'(busB.Data_Out);   o[1] = 32'(busB.col);      o[2] = 32'(busB.row);
                o[3] = 32'(busB.pool_valid); o[4] = 32'(busB.pool_col); o[5] = 32'(busB.pool_row);
                o[6] = 32'(busB.line_end);   o[7] = 32'(busB.frame_end);
                o[8] = 32'(busB.busy);       o[9] = 32'(busB.overflow);
            end
            if (o[3] === 32'd1) pvSeen[k]++;
            checkVal({n, ".Data_Out"},   o[0], 32'(eDout[k]));
            checkVal({n, ".col"},        o[1], 32'(mCol[k]));
            checkVal({n, ".row"},        o[2], 32'(mRow[k]));
            checkVal({n, ".pool_valid"}, o[3], 32'(ePv[k]));
            checkVal({n, ".pool_col"},   o[4], 32'(mPc[k]));
            checkVal({n, ".pool_row"},   o[5], 32'(mPr[k]));
            checkVal({n, ".line_end"},   o[6], 32'(eLe[k]));
            checkVal({n, ".frame_end"},  o[7], 32'(eFe[k]));
            checkVal({n, ".busy"},       o[8], 32'(mBusy[k]));
            checkVal({n, ".overflow"},   o[9], 32'(mOvf[k]));
        end
    endtask

    task automatic applyStimulus(input bit d, input bit c, input bit rn);
        @(negedge clk);
        busA.Data_In = d;  busA.frame_clr = c;
        busB.Data_In = d;  busB.frame_clr = c;
        rst = rn;
        @(posedge clk);
        #1;
        modelStep(d, c, rn);
        checkOutput();
    endtask

    initial begin
        int pcC, lastColC, lastRowC, lastPcC, lastPrC, feC;
        busA.Data_In = 0; busA.frame_clr = 0;
        busB.Data_In = 0; busB.frame_clr = 0;
        busC.Data_In = 0; busC.frame_clr = 0;

        $display("[TB] reset");
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);

        $display("[TB] full frame, back-to-back pixels");
        pvSeen = '{0, 0};
        for (int i = 0; i < 20; i++) applyStimulus(1, 0, 1);
        checkVal("A.frame_pulses", 32'(pvSeen[0]), 32'd4);
        checkVal("B.frame_pulses", 32'(pvSeen[1]), 32'd6);

        $display("[TB] pixels in DONE, then frame_clr");
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 1);
        checkVal("A.overflow_set", 32'(busA.overflow), 32'd1);
        applyStimulus(0, 1, 1);
        checkVal("A.busy_after_clr", 32'(busA.busy), 32'd0);
        checkVal("A.overflow_after_clr", 32'(busA.overflow), 32'd0);

        $display("[TB] gapped frame");
        pvSeen = '{0, 0};
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1, 0, 1);
            if (i == 0) begin
                checkVal("A.restart_col", 32'(busA.col), 32'd0);
                checkVal("A.restart_row", 32'(busA.row), 32'd0);
            end
            applyStimulus(0, 0, 1);
            applyStimulus(0, 0, 1);
        end
        checkVal("A.gapped_pulses", 32'(pvSeen[0]), 32'd4);
        checkVal("B.gapped_pulses", 32'(pvSeen[1]), 32'd6);
        applyStimulus(0, 1, 1);

        $display("[TB] abort mid-frame, clear with coincident pixel");
        for (int i = 0; i < 7; i++) applyStimulus(1, 0, 1);
        applyStimulus(0, 1, 1);
        applyStimulus(1, 1, 1);
        checkVal("A.dropped_pixel", 32'(busA.Data_Out), 32'd0);
        applyStimulus(1, 0, 1);
        checkVal("A.after_abort_col", 32'(busA.col), 32'd0);

        $display("[TB] reset mid-frame");
        for (int i = 0; i < 6; i++) applyStimulus(1, 0, 1);
        applyStimulus(1, 0, 0);
        checkVal("A.busy_after_rst", 32'(busA.busy), 32'd0);
        applyStimulus(0, 0, 1);

        $display("[TB] random stimulus");
        for (int i = 0; i < 400; i++)
            applyStimulus(($urandom % 4) != 0, ($urandom % 40) == 0, ($urandom % 150) != 0);
        applyStimulus(0, 1, 1);

        $display("[TB] full 220x220 frame");
        pcC = 0; lastColC = -1; lastRowC = -1; lastPcC = -1; lastPrC = -1; feC = 0;
        for (int i = 0; i < 220 * 220; i++) begin
            @(negedge clk);
            busC.Data_In = 1;
            @(posedge clk);
            #1;
            if (busC.pool_valid === 1'b1) begin
                pcC++;
                lastColC = int'(busC.col);
                lastRowC = int'(busC.row);
                lastPcC  = int'(busC.pool_col);
                lastPrC  = int'(busC.pool_row);
            end
            if (busC.frame_end === 1'b1) feC++;
        end
        checkVal("C.pulse_count", 32'(pcC), 32'd12100);
        checkVal("C.last_col", 32'(lastColC), 32'd219);
        checkVal("C.last_row", 32'(lastRowC), 32'd219);
        checkVal("C.last_pool_col", 32'(lastPcC), 32'd109);
        checkVal("C.last_pool_row", 32'(lastPrC), 32'd109);
        checkVal("C.frame_end_count", 32'(feC), 32'd1);
        checkVal("C.frame_end_last", 32'(busC.frame_end), 32'd1);
        checkVal("C.line_end_last", 32'(busC.line_end), 32'd1);
        @(negedge clk);
        @(posedge clk);
        #1;
        checkVal("C.overflow", 32'(busC.overflow), 32'd1);
        checkVal("C.ignored_pixel", 32'(busC.Data_Out), 32'd0);
        checkVal("C.busy_done", 32'(busC.busy), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
